// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Operand sign selects, encoded the same way the execute stage drives them.
  localparam logic MULDIV_SIGN   = 1'b1;
  localparam logic MULDIV_UNSIGN = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on {hi, lo}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              mul_en,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] trial;

  always_comb begin
    sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    // Remainder shifted left with the next dividend bit (lo MSB) brought in.
    rem_shift = acc[2*XLEN-1:XLEN-1];
    trial     = rem_shift - {1'b0, operand};
    acc_next  = '0;
    if (mul_en) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/REM sequencer: latches a request, iterates XLEN steps on
// magnitudes, fixes signs and returns low/quotient and high/remainder.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            mul_en_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rs1_sign_i,
  input  logic            rs2_sign_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] data_1_o,
  output logic [XLEN-1:0] data_2_o
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opnd_q;
  logic              mul_q, neg1_q, neg2_q;

  logic              neg1, neg2, div_zero, accept;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    neg1     = (rs1_sign_i == MULDIV_SIGN) & rs1_data_i[XLEN-1];
    neg2     = (rs2_sign_i == MULDIV_SIGN) & rs2_data_i[XLEN-1];
    mag1     = neg1 ? -rs1_data_i : rs1_data_i;
    mag2     = neg2 ? -rs2_data_i : rs2_data_i;
    div_zero = ~mul_en_i & (rs2_data_i == '0);
    accept   = req_valid_i & ~flush_i & (state_q == IDLE);
    prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quo_fix  = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mul_en   (mul_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d      = state_q;
    stall_o      = req_valid_i & ~flush_i & (state_q != DONE);
    resp_valid_o = (state_q == DONE) & ~flush_i;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) state_d = div_zero ? DONE : CALC;
        CALC: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mul_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      data_1_o <= '0;
      data_2_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mul_q  <= mul_en_i;
        neg1_q <= neg1;
        neg2_q <= neg2;
        cnt_q  <= '0;
        // Multiply keeps the multiplier in lo; divide keeps the dividend there.
        acc_q  <= {{XLEN{1'b0}}, (mul_en_i ? mag2 : mag1)};
        opnd_q <= mul_en_i ? mag1 : mag2;
        if (div_zero) begin
          data_1_o <= '1;
          data_2_o <= rs1_data_i;
        end
      end else if (state_q == CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX && !flush_i) begin
        // Results register on entry to DONE so they are visible with the pulse.
        data_1_o <= mul_q ? prod_fix[XLEN-1:0] : quo_fix;
        data_2_o <= mul_q ? prod_fix[2*XLEN-1:XLEN] : rem_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with XLEN = 64.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, mul_en_i, rs1_sign_i, rs2_sign_i, flush_i;
  logic [63:0] rs1_data_i, rs2_data_i;
  logic        stall_o, resp_valid_o;
  logic [63:0] data_1_o, data_2_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        mul;
    logic [63:0] a;
    logic [63:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] e1;
    logic [63:0] e2;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  muldiv_seq #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .mul_en_i     (mul_en_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .rs1_sign_i   (rs1_sign_i),
    .rs2_sign_i   (rs2_sign_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .resp_valid_o (resp_valid_o),
    .data_1_o     (data_1_o),
    .data_2_o     (data_2_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1 of the cycle the request is presented (cycle 0).
  // Returns at posedge+1 of the cycle after DONE with the request still high.
  task automatic run_op(input vec_t v, input string nm, output int lat);
    int  n = 0;
    int  stall_bad = 0;
    bit  got = 0;
    req_valid_i = 1'b1;
    mul_en_i    = v.mul;
    rs1_data_i  = v.a;
    rs2_data_i  = v.b;
    rs1_sign_i  = v.sa;
    rs2_sign_i  = v.sb;
    while (!got && n < 200) begin
      @(negedge clk);
      if (resp_valid_o) got = 1;
      else begin
        if (stall_o !== 1'b1) stall_bad++;
        @(posedge clk); #1;
        n++;
      end
    end
    lat = n;
    chk({nm, ".resp_seen"}, 64'(got), 64'd1);
    chk({nm, ".latency"}, 64'(n), 64'(v.lat));
    chk({nm, ".stall_held"}, 64'(stall_bad), 64'd0);
    chk({nm, ".stall_release"}, 64'(stall_o), 64'd0);
    chk({nm, ".data_1"}, data_1_o, v.e1);
    chk({nm, ".data_2"}, data_2_o, v.e2);
    @(posedge clk); #1;
    chk({nm, ".pulse_width"}, 64'(resp_valid_o), 64'd0);
  endtask

  initial begin
    int   l1, l2, pulses;
    vec_t v;
    vecs[0]  = '{1'b1, 64'd7, -64'sd3, MULDIV_SIGN, MULDIV_SIGN, 64'hFFFF_FFFF_FFFF_FFEB, '1, 66};
    vecs[1]  = '{1'b1, '1, 64'd2, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
    vecs[2]  = '{1'b0, -64'sd7, 64'd2, MULDIV_SIGN, MULDIV_SIGN, -64'sd3, '1, 66};
    vecs[3]  = '{1'b0, 64'd100, 64'd7, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd14, 64'd2, 66};
    vecs[4]  = '{1'b0, 64'd5, 64'd0, MULDIV_SIGN, MULDIV_SIGN, '1, 64'd5, 1};
    vecs[5]  = '{1'b0, 64'h8000_0000_0000_0000, '1, MULDIV_SIGN, MULDIV_SIGN, 64'h8000_0000_0000_0000, 64'd0, 66};
    vecs[6]  = '{1'b1, '1, '1, MULDIV_SIGN, MULDIV_SIGN, 64'd1, 64'd0, 66};
    vecs[7]  = '{1'b1, -64'sd2, 64'd3, MULDIV_SIGN, MULDIV_UNSIGN, 64'hFFFF_FFFF_FFFF_FFFA, '1, 66};
    vecs[8]  = '{1'b0, 64'd7, -64'sd2, MULDIV_SIGN, MULDIV_SIGN, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
    vecs[9]  = '{1'b0, '1, 64'd0, MULDIV_UNSIGN, MULDIV_UNSIGN, '1, '1, 1};
    vecs[10] = '{1'b0, -64'sd5, 64'd0, MULDIV_SIGN, MULDIV_SIGN, '1, 64'hFFFF_FFFF_FFFF_FFFB, 1};
    vecs[11] = '{1'b1, 64'h1_0000_0000, 64'h1_0000_0000, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd0, 64'd1, 66};

    rst = 1'b1; req_valid_i = 1'b0; mul_en_i = 1'b0; flush_i = 1'b0;
    rs1_data_i = '0; rs2_data_i = '0; rs1_sign_i = 1'b0; rs2_sign_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.data_1", data_1_o, 64'd0);
    chk("reset.data_2", data_2_o, 64'd0);
    chk("reset.resp", 64'(resp_valid_o), 64'd0);
    chk("reset.stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), l1);
      req_valid_i = 1'b0;
      @(posedge clk); #1;
    end

    // Flush in cycle 30 of a multiply: no response, results untouched.
    v = '{1'b1, 64'd123, 64'd456, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd0, 64'd0, 66};
    req_valid_i = 1'b1; mul_en_i = v.mul; rs1_data_i = v.a; rs2_data_i = v.b;
    rs1_sign_i = v.sa; rs2_sign_i = v.sb;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush.stall", 64'(stall_o), 64'd0);
    chk("flush.resp", 64'(resp_valid_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (resp_valid_o) pulses++;
    end
    chk("flush.no_resp", 64'(pulses), 64'd0);
    chk("flush.data_1_kept", data_1_o, vecs[11].e1);
    chk("flush.data_2_kept", data_2_o, vecs[11].e2);
    @(posedge clk); #1;

    // Back-to-back multiplies: second accepted the cycle after the first DONE.
    v = '{1'b1, 64'd2, 64'd3, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd6, 64'd0, 66};
    run_op(v, "b2b_first", l1);
    v = '{1'b1, 64'd4, 64'd5, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd20, 64'd0, 66};
    run_op(v, "b2b_second", l2);
    chk("b2b.second_done_cycle", 64'(l1 + 1 + l2), 64'd133);
    req_valid_i = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in cycle 10 of a divide.
    req_valid_i = 1'b1; mul_en_i = 1'b0; rs1_data_i = 64'd100; rs2_data_i = 64'd7;
    rs1_sign_i = MULDIV_UNSIGN; rs2_sign_i = MULDIV_UNSIGN;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; req_valid_i = 1'b0;
    #1;
    chk("rst_mid.data_1", data_1_o, 64'd0);
    chk("rst_mid.data_2", data_2_o, 64'd0);
    chk("rst_mid.resp", 64'(resp_valid_o), 64'd0);
    chk("rst_mid.stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[3], "after_rst", l1);
    req_valid_i = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
